// File: rtl/dsk_ram_arbiter.sv
// Arbitrates the single disk-image RAM port between the SD loader, the floppy read path
// and the floppy write-back path: round-robin with a loader override, with a stall watchdog.
module dsk_ram_arbiter #(
  parameter int AW    = 20,
  parameter int DW    = 32,
  parameter int TMO_W = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prio0,
  input  logic          req0_read,
  input  logic          req0_wrte,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ack,
  input  logic          req1_read,
  input  logic          req1_wrte,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ack,
  input  logic          req2_read,
  input  logic          req2_wrte,
  input  logic [AW-1:0] req2_addr,
  input  logic [DW-1:0] req2_wdata,
  output logic          req2_ack,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic [2:0]    grant,
  output logic [AW-1:0] dsk_addr,
  output logic [DW-1:0] dsk_dout,
  input  logic [DW-1:0] dsk_din,
  output logic          dsk_read,
  output logic          dsk_wrte,
  input  logic          dsk_busy,
  input  logic          dsk_asck
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  // Abort on the last counted cycle so the command is held exactly 2**TMO_W-1 cycles.
  localparam logic [TMO_W-1:0] WD_MAX = '1;
  localparam logic [TMO_W-1:0] WD_LIM = WD_MAX - 1'b1;

  state_t         state_q, state_d;
  logic [2:0]     grant_q, grant_d;
  logic [2:0]     ack_q, ack_d;
  logic [1:0]     owner_q, owner_d;
  logic [1:0]     rr_q, rr_d;
  logic [TMO_W-1:0] wdog_q, wdog_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  dout_q, dout_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           rd_q, rd_d;
  logic           wr_q, wr_d;
  logic           err_q, err_d;

  logic [2:0]     pend;
  logic [1:0]     win;
  logic           done_ok;

  function automatic logic [1:0] arb_pick(input logic [2:0] p, input logic [1:0] ptr,
                                          input logic pr);
    logic [1:0] a, b, c;
    case (ptr)
      2'd1:    begin a = 2'd1; b = 2'd2; c = 2'd0; end
      2'd2:    begin a = 2'd2; b = 2'd0; c = 2'd1; end
      default: begin a = 2'd0; b = 2'd1; c = 2'd2; end
    endcase
    if (pr && p[0]) return 2'd0;
    if (p[a]) return a;
    if (p[b]) return b;
    return c;
  endfunction

  function automatic logic [1:0] next_ptr(input logic [1:0] own);
    return (own >= 2'd2) ? 2'd0 : own + 2'd1;
  endfunction

  assign pend = {req2_read | req2_wrte, req1_read | req1_wrte, req0_read | req0_wrte};
  assign win  = arb_pick(pend, rr_q, prio0);
  assign done_ok = (state_q == S_ISSUE) ? (dsk_busy && dsk_asck) : dsk_asck;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = 3'b000;
    owner_d = owner_q;
    rr_d    = rr_q;
    wdog_d  = wdog_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = 1'b0;

    case (state_q)
      S_ISSUE, S_WAIT: begin
        if (done_ok || wdog_q == WD_LIM) begin
          state_d = S_DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          grant_d = 3'b000;
          ack_d   = 3'b001 << owner_q;
          err_d   = !done_ok;
          rdata_d = done_ok ? dsk_din : '0;
          rr_d    = next_ptr(owner_q);
        end else begin
          if (wdog_q != WD_MAX) wdog_d = wdog_q + 1'b1;
          if (state_q == S_ISSUE && dsk_busy) state_d = S_WAIT;
        end
      end
      default: ;
    endcase

    // IDLE and DONE both arbitrate; DONE already sees the advanced pointer.
    if ((state_q == S_IDLE || state_q == S_DONE) && (|pend)) begin
      state_d = S_ISSUE;
      owner_d = win;
      grant_d = 3'b001 << win;
      wdog_d  = '0;
      case (win)
        2'd1: begin
          addr_d = req1_addr; dout_d = req1_wdata;
          wr_d = req1_wrte;   rd_d = req1_read & ~req1_wrte;
        end
        2'd2: begin
          addr_d = req2_addr; dout_d = req2_wdata;
          wr_d = req2_wrte;   rd_d = req2_read & ~req2_wrte;
        end
        default: begin
          addr_d = req0_addr; dout_d = req0_wdata;
          wr_d = req0_wrte;   rd_d = req0_read & ~req0_wrte;
        end
      endcase
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      wdog_q  <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      wdog_q  <= wdog_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  assign req0_ack = ack_q[0];
  assign req1_ack = ack_q[1];
  assign req2_ack = ack_q[2];
  assign rdata    = rdata_q;
  assign err      = err_q;
  assign grant    = grant_q;
  assign dsk_addr = addr_q;
  assign dsk_dout = dout_q;
  assign dsk_read = rd_q;
  assign dsk_wrte = wr_q;

endmodule

// File: tb/tb_dsk_ram_arbiter.sv
// Directed bench for dsk_ram_arbiter: table of single-requester transactions plus
// contention, priority, reset-in-wait and watchdog sequences against a small RAM responder.
module tb_dsk_ram_arbiter;
  localparam int AW = 20, DW = 32, TMO_W = 4;

  logic clk = 1'b0, reset = 1'b1, prio0 = 1'b0;
  logic req0_read = 0, req0_wrte = 0, req1_read = 0, req1_wrte = 0, req2_read = 0, req2_wrte = 0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0, req2_addr = '0;
  logic [DW-1:0] req0_wdata = '0, req1_wdata = '0, req2_wdata = '0;
  logic req0_ack, req1_ack, req2_ack, err, dsk_read, dsk_wrte;
  logic [DW-1:0] rdata, dsk_dout;
  logic [2:0] grant;
  logic [AW-1:0] dsk_addr;
  logic [DW-1:0] dsk_din = '0;
  logic dsk_busy = 1'b0, dsk_asck = 1'b0;

  dsk_ram_arbiter #(.AW(AW), .DW(DW), .TMO_W(TMO_W)) dut (
    .clk(clk), .reset(reset), .prio0(prio0),
    .req0_read(req0_read), .req0_wrte(req0_wrte), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ack(req0_ack),
    .req1_read(req1_read), .req1_wrte(req1_wrte), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ack(req1_ack),
    .req2_read(req2_read), .req2_wrte(req2_wrte), .req2_addr(req2_addr),
    .req2_wdata(req2_wdata), .req2_ack(req2_ack),
    .rdata(rdata), .err(err), .grant(grant), .dsk_addr(dsk_addr), .dsk_dout(dsk_dout),
    .dsk_din(dsk_din), .dsk_read(dsk_read), .dsk_wrte(dsk_wrte),
    .dsk_busy(dsk_busy), .dsk_asck(dsk_asck)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;

  // RAM responder: busy from command cycle busy_at onward, asck on command cycle asck_at.
  int ram_cnt = 0, ram_busy_at = 2, ram_asck_at = 4;
  bit ram_en = 1'b1;
  logic [DW-1:0] ram_din = '0;
  always @(posedge clk) begin
    #1;
    if ((dsk_read || dsk_wrte) && ram_en) ram_cnt++;
    else ram_cnt = 0;
    dsk_busy = ram_en && (ram_cnt != 0) && (ram_cnt >= ram_busy_at);
    dsk_asck = ram_en && (ram_cnt == ram_asck_at);
    dsk_din  = dsk_asck ? ram_din : 32'h0BAD0BAD;
  end

  typedef struct {
    int            who;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] din;
    int            busy_at;
    int            asck_at;
    logic          exp_wr;
    logic [DW-1:0] exp_rdata;
    int            exp_cyc;
  } vec_t;
  vec_t vt[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int who, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    case (who)
      0: begin req0_read = rd; req0_wrte = wr; req0_addr = a; req0_wdata = d; end
      1: begin req1_read = rd; req1_wrte = wr; req1_addr = a; req1_wdata = d; end
      default: begin req2_read = rd; req2_wrte = wr; req2_addr = a; req2_wdata = d; end
    endcase
  endtask

  task automatic drop_req(input int who);
    case (who)
      0: begin req0_read = 0; req0_wrte = 0; end
      1: begin req1_read = 0; req1_wrte = 0; end
      default: begin req2_read = 0; req2_wrte = 0; end
    endcase
  endtask

  // Follows one transaction from the current cycle to its ack and checks every phase.
  task automatic txn(input string tag, input int who, input logic exp_wr,
                     input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                     input logic [DW-1:0] er, input logic ee, input int ecyc,
                     input int elat, input bit drop);
    int lat, cyc;
    bit got;
    lat = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick(); lat++;
      if (dsk_read || dsk_wrte) got = 1;
    end
    chk($sformatf("%s cmd_seen", tag), 64'(got), 64'd1);
    if (!got) return;
    chk($sformatf("%s latency", tag), 64'(lat), 64'(elat));
    chk($sformatf("%s grant", tag), 64'(grant), 64'(3'b001 << who));
    chk($sformatf("%s dsk_wrte", tag), 64'(dsk_wrte), 64'(exp_wr));
    chk($sformatf("%s dsk_read", tag), 64'(dsk_read), 64'(!exp_wr));
    chk($sformatf("%s dsk_addr", tag), 64'(dsk_addr), 64'(ea));
    if (exp_wr) chk($sformatf("%s dsk_dout", tag), 64'(dsk_dout), 64'(ed));
    cyc = 1; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if ({req2_ack, req1_ack, req0_ack} != 3'b000) got = 1;
      else if (dsk_read || dsk_wrte) cyc++;
    end
    chk($sformatf("%s ack_seen", tag), 64'(got), 64'd1);
    if (!got) return;
    chk($sformatf("%s ack_vec", tag), 64'({req2_ack, req1_ack, req0_ack}), 64'(3'b001 << who));
    chk($sformatf("%s rdata", tag), 64'(rdata), 64'(er));
    chk($sformatf("%s err", tag), 64'(err), 64'(ee));
    chk($sformatf("%s cmd_low_at_ack", tag), 64'(dsk_read | dsk_wrte), 64'd0);
    chk($sformatf("%s grant_clear", tag), 64'(grant), 64'd0);
    chk($sformatf("%s cmd_cycles", tag), 64'(cyc), 64'(ecyc));
    if (drop) drop_req(who);
  endtask

  task automatic chk_all_zero(input string tag);
    chk($sformatf("%s grant", tag), 64'(grant), 64'd0);
    chk($sformatf("%s acks", tag), 64'({req2_ack, req1_ack, req0_ack}), 64'd0);
    chk($sformatf("%s err", tag), 64'(err), 64'd0);
    chk($sformatf("%s cmd", tag), 64'({dsk_read, dsk_wrte}), 64'd0);
    chk($sformatf("%s dsk_addr", tag), 64'(dsk_addr), 64'd0);
    chk($sformatf("%s dsk_dout", tag), 64'(dsk_dout), 64'd0);
    chk($sformatf("%s rdata", tag), 64'(rdata), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vt[0] = '{1, 1'b1, 1'b0, 20'h32000, 32'h0,        32'hDEADBEEF, 2, 4, 1'b0, 32'hDEADBEEF, 4};
    vt[1] = '{0, 1'b1, 1'b0, 20'h00000, 32'h0,        32'h00000001, 1, 1, 1'b0, 32'h00000001, 1};
    vt[2] = '{2, 1'b1, 1'b1, 20'h9C400, 32'h12345678, 32'hA5A5A5A5, 2, 4, 1'b1, 32'hA5A5A5A5, 4};
    vt[3] = '{0, 1'b0, 1'b1, 20'hC7FFF, 32'hFFFFFFFF, 32'h00000000, 3, 3, 1'b1, 32'h00000000, 3};
    vt[4] = '{1, 1'b1, 1'b0, 20'hFFFFF, 32'h0,        32'h80000000, 1, 6, 1'b0, 32'h80000000, 6};

    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      ram_busy_at = vt[v].busy_at;
      ram_asck_at = vt[v].asck_at;
      ram_din     = vt[v].din;
      set_req(vt[v].who, vt[v].rd, vt[v].wr, vt[v].addr, vt[v].wdata);
      txn($sformatf("vec%0d", v), vt[v].who, vt[v].exp_wr, vt[v].addr, vt[v].wdata,
          vt[v].exp_rdata, 1'b0, vt[v].exp_cyc, 1, 1'b1);
      tick();
      chk($sformatf("vec%0d idle_grant", v), 64'(grant), 64'd0);
    end

    // Contention from a fresh pointer: 0, 1, 2 back to back.
    reset = 1'b1; tick(); reset = 1'b0;
    ram_busy_at = 2; ram_asck_at = 4; ram_din = 32'h11110000;
    set_req(0, 1, 0, 20'h00010, 0);
    set_req(1, 1, 0, 20'h00020, 0);
    set_req(2, 1, 0, 20'h00030, 0);
    txn("cont0", 0, 1'b0, 20'h00010, 0, 32'h11110000, 1'b0, 4, 1, 1'b1);
    txn("cont1", 1, 1'b0, 20'h00020, 0, 32'h11110000, 1'b0, 4, 1, 1'b1);
    txn("cont2", 2, 1'b0, 20'h00030, 0, 32'h11110000, 1'b0, 4, 1, 1'b1);
    tick();

    // Loader override: req0 held keeps winning until prio0 drops, then req2 goes next.
    reset = 1'b1; tick(); reset = 1'b0;
    prio0 = 1'b1; ram_din = 32'h22220000;
    set_req(0, 1, 0, 20'h00100, 0);
    set_req(2, 1, 0, 20'h00200, 0);
    for (int k = 0; k < 3; k++)
      txn($sformatf("prio%0d", k), 0, 1'b0, 20'h00100, 0, 32'h22220000, 1'b0, 4, 1, 1'b0);
    prio0 = 1'b0;
    txn("prio_rel", 2, 1'b0, 20'h00200, 0, 32'h22220000, 1'b0, 4, 1, 1'b1);
    drop_req(0);
    tick();
    chk("prio_idle grant", 64'(grant), 64'd0);

    // Reset while waiting for the RAM, then the held request is served again.
    ram_busy_at = 2; ram_asck_at = 6; ram_din = 32'hCAFEF00D;
    set_req(1, 1, 0, 20'h00042, 0);
    tick();
    chk("rstw cmd", 64'(dsk_read), 64'd1);
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk_all_zero("rstw");
    txn("rstw_retry", 1, 1'b0, 20'h00042, 0, 32'hCAFEF00D, 1'b0, 6, 1, 1'b1);
    tick();

    // Watchdog: RAM never answers, abort after 15 command cycles.
    ram_en = 1'b0;
    set_req(1, 1, 0, 20'h12345, 0);
    txn("tmo", 1, 1'b0, 20'h12345, 0, 32'h0, 1'b1, 15, 1, 1'b1);
    ram_en = 1'b1;
    tick();
    chk("tmo err_pulse", 64'(err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
